division_top: RTL and testbench

Multi-cycle unsigned restoring divider, the inverse companion of `multiplication_top`. It takes a 2·WIDTH-bit dividend (a product-width value) and a WIDTH-bit divisor and returns a WIDTH-bit quotient and remainder. It uses the same level-sensitive `start` / `ready` handshake as the multiplier, so a single controller or bench can drive both blocks interchangeably. Radix-2, one quotient bit per clock.

---
 rtl/division_top.sv | 138 +++++++++++++
 tb/tb_division_top.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/division_top.sv
// division_top: radix-2 restoring divider, 2*WIDTH / WIDTH -> WIDTH.
// Ports: clk, reset (sync, active-low), start, dividend_in, divisor_in,
//        quotient, remainder, ready, div_by_zero, overflow.
module division_top #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0]   divisor_in,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               ready,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] dvsr;

    logic             accept;
    logic             is_dz;
    logic             is_ov;
    logic             last;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] prem_nx;
    logic [WIDTH-1:0] shreg_nx;

    always_comb begin
        accept = start && (state == IDLE || state == DONE);
        is_dz  = (divisor_in == '0);
        // Made exclusive of is_dz so divide-by-zero wins.
        is_ov  = !is_dz &&
                 (dividend_in[2*WIDTH-1:WIDTH] >= divisor_in);
        last   = (state == BUSY) && (count == '0);
    end

    // Trial needs the extra top bit: the shifted partial
    // remainder can reach 2*divisor-1, beyond WIDTH bits.
    always_comb begin
        trial    = {prem, shreg[WIDTH-1]};
        fits     = (trial >= {1'b0, dvsr});
        // When fits, the difference is < dvsr, so the
        // low WIDTH bits of the subtraction are exact.
        prem_nx  = fits ? (trial[WIDTH-1:0] - dvsr)
                        : trial[WIDTH-1:0];
        shreg_nx = {shreg[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nx = (is_dz || is_ov) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count       <= '0;
            prem        <= '0;
            shreg       <= '0;
            dvsr        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            dvsr        <= divisor_in;
            prem        <= dividend_in[2*WIDTH-1:WIDTH];
            shreg       <= dividend_in[WIDTH-1:0];
            count       <= CW'(WIDTH - 1);
            quotient    <= '0;
            remainder   <= '0;
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            unique case (1'b1)
                is_dz: begin
                    div_by_zero <= 1'b1;
                    quotient    <= '1;
                    remainder   <= dividend_in[WIDTH-1:0];
                    ready       <= 1'b1;
                end
                is_ov: begin
                    overflow <= 1'b1;
                    quotient <= '1;
                    ready    <= 1'b1;
                end
                default: begin
                end
            endcase
        end else if (state == BUSY) begin
            prem  <= prem_nx;
            shreg <= shreg_nx;
            if (last) begin
                quotient  <= shreg_nx;
                remainder <= prem_nx;
                ready     <= 1'b1;
            end else begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_division_top.sv
// tb_division_top: directed checks for division_top.
// Hand-computed vectors, error paths, chained ops, disruptions.
module tb_division_top;

    localparam int W = 64;

    logic           clk;
    logic           reset;
    logic           start;
    logic [2*W-1:0] dividend_in;
    logic [W-1:0]   divisor_in;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           ready;
    logic           div_by_zero;
    logic           overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2*W-1:0] cd [100];
    logic [W-1:0]   cb [100];
    logic [W-1:0]   cq [100];
    logic [W-1:0]   cr [100];

    localparam logic [W-1:0] ONES = {W{1'b1}};

    division_top #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend_in (dividend_in),
        .divisor_in  (divisor_in),
        .quotient    (quotient),
        .remainder   (remainder),
        .ready       (ready),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    task automatic do_op(input string tag,
                         input logic [2*W-1:0] dvd,
                         input logic [W-1:0] dvs,
                         input logic [W-1:0] eq,
                         input logic [W-1:0] er,
                         input logic edz,
                         input logic eov,
                         input int elat);
        int lat;
        dividend_in = dvd;
        divisor_in  = dvs;
        start       = 1'b1;
        tick();
        start = 1'b0;
        if (elat > 1) check({tag, "_rdy_low"}, ready, 0);
        lat = 1;
        while (!ready && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, elat);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dz"}, div_by_zero, edz);
        check({tag, "_ov"}, overflow, eov);
    endtask

    initial begin
        int gap;
        int lat;
        logic seen;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;

        reset       = 1'b0;
        start       = 1'b0;
        dividend_in = '0;
        divisor_in  = '0;
        tick();
        tick();
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_rdy", ready, 0);
        check("rst_dz", div_by_zero, 0);
        check("rst_ov", overflow, 0);
        check("rst_cnt", dut.count, 0);
        check("rst_state", dut.state, 0);
        reset = 1'b1;
        tick();

        do_op("d459", 128'd459, 64'd27, 64'd17, 64'd0,
              1'b0, 1'b0, 65);
        do_op("d1000", 128'd1000, 64'd7, 64'd142, 64'd6,
              1'b0, 1'b0, 65);
        do_op("dmax", {ONES - 64'd1, 64'd1}, ONES, ONES, 64'd0,
              1'b0, 1'b0, 65);
        do_op("dz", 128'd5, 64'd0, ONES, 64'd5,
              1'b1, 1'b0, 1);
        do_op("ov", {64'd3, 64'd0}, 64'd3, ONES, 64'd0,
              1'b0, 1'b1, 1);
        do_op("after_err", 128'd100, 64'd9, 64'd11, 64'd1,
              1'b0, 1'b0, 65);

        for (int i = 0; i < 100; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} | 64'd1;
            r = {$urandom, $urandom} % b;
            cb[i] = b;
            cq[i] = a;
            cr[i] = r;
            cd[i] = {64'd0, a} * {64'd0, b} + {64'd0, r};
        end
        dividend_in = cd[0];
        divisor_in  = cb[0];
        start       = 1'b1;
        tick();
        gap = 0;
        for (int i = 0; i < 100; i++) begin
            while (!ready && gap < 200) begin
                tick();
                gap++;
            end
            check("chain_gap", gap, (i == 0) ? 64 : 65);
            check("chain_q", quotient, cq[i]);
            check("chain_r", remainder, cr[i]);
            if (i < 99) begin
                dividend_in = cd[i+1];
                divisor_in  = cb[i+1];
            end else begin
                start = 1'b0;
            end
            tick();
            gap = 1;
            if (i < 99) check("chain_pulse", ready, 0);
        end
        start = 1'b0;
        tick();

        dividend_in = 128'd1000;
        divisor_in  = 64'd7;
        start       = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        reset = 1'b0;
        tick();
        check("mid_rst_q", quotient, 0);
        check("mid_rst_r", remainder, 0);
        check("mid_rst_rdy", ready, 0);
        check("mid_rst_state", dut.state, 0);
        reset = 1'b1;
        seen  = 1'b0;
        repeat (70) begin
            tick();
            if (ready) seen = 1'b1;
        end
        check("mid_rst_no_rdy", seen, 0);
        do_op("post_rst", 128'd459, 64'd27, 64'd17, 64'd0,
              1'b0, 1'b0, 65);

        dividend_in = 128'd1000;
        divisor_in  = 64'd7;
        start       = 1'b1;
        tick();
        lat = 1;
        repeat (40) begin
            start       = ~start;
            dividend_in = 128'd12345;
            divisor_in  = 64'd0;
            tick();
            lat++;
        end
        start = 1'b0;
        while (!ready && lat < 200) begin
            tick();
            lat++;
        end
        check("tog_lat", lat, 65);
        check("tog_q", quotient, 64'd142);
        check("tog_r", remainder, 64'd6);
        check("tog_dz", div_by_zero, 0);
        tick();
        check("done_hold_q", quotient, 64'd142);
        check("done_hold_rdy", ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
